// File: rtl/sa48_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa48_pkg
// Brief    : Shared sizing constants for the 48-bit sequential adder slice.
// Revision : 1.0  initial release
// ============================================================================
package sa48_pkg;

    localparam int SA48_WIDTH  = 48;
    localparam int SA48_CHUNK  = 12;
    localparam int SA48_NCHUNK = SA48_WIDTH / SA48_CHUNK;
    // Counter must be able to represent NCHUNK itself (saturation value).
    localparam int SA48_CNT_W  = $clog2(SA48_NCHUNK + 1);

endpackage : sa48_pkg
`default_nettype wire

// File: rtl/sa48_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : sa48_chunk_adder
// Brief    : Combinational CHUNK-bit adder slice with carry and signed overflow.
// Revision : 1.0  initial release
// ============================================================================
module sa48_chunk_adder
    import sa48_pkg::*;
#(
    parameter int CHUNK = SA48_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             ovf
);

    logic [CHUNK:0] w_total;

    assign w_total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s       = w_total[CHUNK-1:0];
    assign cout    = w_total[CHUNK];
    // Overflow only meaningful on the most-significant slice.
    assign ovf     = (a[CHUNK-1] == b[CHUNK-1]) && (w_total[CHUNK-1] != a[CHUNK-1]);

endmodule : sa48_chunk_adder
`default_nettype wire

// File: rtl/sa48_datapath.sv
`default_nettype none
// ============================================================================
// Module   : sa48_datapath
// Brief    : Chunk-serial 48-bit adder datapath driven by an external controller.
// Revision : 1.0  initial release
// ============================================================================
module sa48_datapath
    import sa48_pkg::*;
#(
    parameter int WIDTH = SA48_WIDTH,
    parameter int CHUNK = SA48_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loadOperands,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             carryIn,
    input  logic             shiftNext,
    input  logic             resultReady,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow,
    output logic             sumValid,
    output logic             seqError
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(NCHUNK + 1);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] c_CNT_DONE = CNT_W'(NCHUNK);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("sa48_datapath: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carryOut;
    logic             r_overflow;
    logic             r_sumValid;
    logic             r_seqError;

    logic [CHUNK-1:0] w_chunkSum;
    logic             w_chunkCout;
    logic             w_chunkOvf;

    sa48_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (r_opA[CHUNK-1:0]),
        .b    (r_opB[CHUNK-1:0]),
        .cin  (r_carry),
        .s    (w_chunkSum),
        .cout (w_chunkCout),
        .ovf  (w_chunkOvf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
            r_sumValid <= 1'b0;
            r_seqError <= 1'b0;
        end else if (loadOperands) begin
            // A coincident shiftNext is intentionally dropped here.
            r_opA      <= opA;
            r_opB      <= opB;
            r_carry    <= carryIn;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
            r_sumValid <= 1'b0;
            r_seqError <= 1'b0;
        end else if (shiftNext) begin
            if (r_cnt < c_CNT_DONE) begin
                r_carry <= w_chunkCout;
                r_sum   <= {w_chunkSum, r_sum[WIDTH-1:CHUNK]};
                r_opA   <= r_opA >> CHUNK;
                r_opB   <= r_opB >> CHUNK;
                r_cnt   <= r_cnt + 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    r_sumValid <= 1'b1;
                    r_carryOut <= w_chunkCout;
                    r_overflow <= w_chunkOvf;
                end
            end else begin
                r_seqError <= 1'b1;
            end
            if (resultReady) begin
                r_seqError <= 1'b1;
            end
        end
    end

    assign sum      = r_sum;
    assign carryOut = r_carryOut;
    assign overflow = r_overflow;
    assign sumValid = r_sumValid;
    assign seqError = r_seqError;

endmodule : sa48_datapath
`default_nettype wire

// File: tb/tb_sa48_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa48_datapath
// Brief    : Directed self-checking bench for the sa48 chunk-serial datapath.
// Revision : 1.0  initial release
// ============================================================================
module tb_sa48_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        loadOperands;
    logic [47:0] opA;
    logic [47:0] opB;
    logic        carryIn;
    logic        shiftNext;
    logic        resultReady;
    logic [47:0] sum;
    logic        carryOut;
    logic        overflow;
    logic        sumValid;
    logic        seqError;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sa48_datapath u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .loadOperands (loadOperands),
        .opA          (opA),
        .opB          (opB),
        .carryIn      (carryIn),
        .shiftNext    (shiftNext),
        .resultReady  (resultReady),
        .sum          (sum),
        .carryOut     (carryOut),
        .overflow     (overflow),
        .sumValid     (sumValid),
        .seqError     (seqError)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [47:0] a, input logic [47:0] b, input logic cin);
        loadOperands = 1'b1;
        opA          = a;
        opB          = b;
        carryIn      = cin;
        tick();
        loadOperands = 1'b0;
    endtask

    task automatic shifts(input int n);
        shiftNext = 1'b1;
        for (int i = 0; i < n; i++) tick();
        shiftNext = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        loadOperands = 1'b0;
        opA          = '0;
        opB          = '0;
        carryIn      = 1'b0;
        shiftNext    = 1'b0;
        resultReady  = 1'b0;
        tick();
        chk("rst_sum", sum, 48'h0);
        chk("rst_valid", {47'h0, sumValid}, 48'h0);
        chk("rst_err", {47'h0, seqError}, 48'h0);
        chk("rst_cout", {47'h0, carryOut}, 48'h0);
        chk("rst_ovf", {47'h0, overflow}, 48'h0);
        rst_n = 1'b1;

        // Carry propagation out of chunk 0
        load(48'h0000_0000_0FFF, 48'h0, 1'b1);
        shifts(3);
        chk("t1_valid_early", {47'h0, sumValid}, 48'h0);
        shifts(1);
        chk("t1_sum", sum, 48'h0000_0000_1000);
        chk("t1_cout", {47'h0, carryOut}, 48'h0);
        chk("t1_ovf", {47'h0, overflow}, 48'h0);
        chk("t1_valid", {47'h0, sumValid}, 48'h1);
        chk("t1_err", {47'h0, seqError}, 48'h0);

        // Extra shift after completion
        shifts(1);
        chk("t4_err", {47'h0, seqError}, 48'h1);
        chk("t4_sum_hold", sum, 48'h0000_0000_1000);
        chk("t4_valid_hold", {47'h0, sumValid}, 48'h1);
        load(48'h0, 48'h0, 1'b0);
        chk("t4_err_clr", {47'h0, seqError}, 48'h0);
        chk("t4_valid_clr", {47'h0, sumValid}, 48'h0);

        // Full-width wrap
        load(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0);
        shifts(4);
        chk("t2_sum", sum, 48'h0);
        chk("t2_cout", {47'h0, carryOut}, 48'h1);
        chk("t2_ovf", {47'h0, overflow}, 48'h0);

        // Signed overflow, positive direction
        load(48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0);
        shifts(4);
        chk("t3a_sum", sum, 48'h8000_0000_0000);
        chk("t3a_ovf", {47'h0, overflow}, 48'h1);
        chk("t3a_cout", {47'h0, carryOut}, 48'h0);

        // Signed overflow, negative direction
        load(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0);
        shifts(4);
        chk("t3b_sum", sum, 48'h0);
        chk("t3b_cout", {47'h0, carryOut}, 48'h1);
        chk("t3b_ovf", {47'h0, overflow}, 48'h1);

        // Load wins over a coincident shift
        load(48'h0000_0000_0555, 48'h0000_0000_0555, 1'b0);
        shifts(2);
        shiftNext = 1'b1;
        load(48'h1, 48'h2, 1'b0);
        shiftNext = 1'b0;
        chk("t5_sum_clr", sum, 48'h0);
        chk("t5_err", {47'h0, seqError}, 48'h0);
        chk("t5_valid", {47'h0, sumValid}, 48'h0);
        shifts(3);
        chk("t5_valid_early", {47'h0, sumValid}, 48'h0);
        shifts(1);
        chk("t5_sum", sum, 48'h3);
        chk("t5_valid_done", {47'h0, sumValid}, 48'h1);
        chk("t5_err_done", {47'h0, seqError}, 48'h0);

        // Reset mid-operation, then shift while controller reports ready
        load(48'h0000_0000_0123, 48'h0000_0000_0456, 1'b0);
        shifts(2);
        chk("t6_partial", sum, 48'h0005_7900_0000);
        rst_n = 1'b0;
        #1;
        chk("t6_hold", sum, 48'h0005_7900_0000);
        tick();
        chk("t6_rst_sum", sum, 48'h0);
        chk("t6_rst_flags", {43'h0, sumValid, seqError, carryOut, overflow, 1'b0}, 48'h0);
        rst_n       = 1'b1;
        resultReady = 1'b1;
        shifts(1);
        resultReady = 1'b0;
        chk("t6_ready_err", {47'h0, seqError}, 48'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sa48_datapath
`default_nettype wire
